adder_response_checker: RTL and testbench
=========================================

# adder_response_checker

Self-checking response analyzer for the WIDTH-bit adder family. It receives each applied vector together with the adder's response: operands a and b, carry-in cin, sum s and carry-out cout. For every vector it compares the response against a golden sum, counts mismatches, captures the first failing vector and compresses all responses into a 16-bit signature. It is the receiving end of the adder stimulus stream and is used in simulation and in on-chip self-test. One run is one exhaustive sweep of 2^(2·WIDTH+1) vectors.

## Interface
Parameters:
- WIDTH, 4, operand width.
- NVEC, derived localparam 2^(2·WIDTH+1) (512 at WIDTH=4), number of vectors per run.
- CW, derived localparam 2·WIDTH+2, width of the counters.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  begins a run; accepted only in IDLE or DONE.
- vld  in  1  qualifies a, b, cin, s and cout this cycle.
- a, b  in  WIDTH  applied operands.
- cin  in  1  applied carry-in.
- s  in  WIDTH  sum returned by the adder.
- cout  in  1  carry-out returned by the adder.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- pass  out  1  high in DONE when err_cnt is 0.
- vec_cnt  out  CW  number of vectors accepted in the current run.
- err_cnt  out  CW  number of mismatching vectors in the current run.
- ff_valid  out  1  a first failure has been captured.
- ff_a, ff_b  out  WIDTH  operands of the first failing vector.
- ff_cin  out  1  carry-in of the first failing vector.
- sig  out  16  response signature.

## Operation
- State IDLE:
  - start moves to RUN.
  - On that transition: vec_cnt, err_cnt and ff_* are cleared, ff_valid goes to 0 and sig is seeded to 16'hFFFF.
  - vld is ignored in IDLE.
- State RUN: each cycle with vld high is one vector.
  - Golden value: exp = a + b + cin, computed at WIDTH+1 bits with zero extension. The check compares {cout,s} against exp.
  - vec_cnt increments by 1.
  - On a mismatch, err_cnt increments by 1. If ff_valid is 0, ff_a, ff_b and ff_cin load the vector and ff_valid goes to 1. Later failures do not overwrite the capture.
  - sig updates as a Galois MISR with mask 16'h1021: sig <= ({sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0)) ^ zero-extend({cout,s}).
  - The vector that makes vec_cnt reach NVEC moves the block to DONE.
- State DONE:
  - All results hold.
  - start re-enters RUN with the same clears and seed.
  - vld is ignored.
- Vector order is not checked. Duplicate vectors are counted like any other.
- Width rules: with CW bits, the counters hold up to 2·NVEC−1, so neither counter can wrap within a run.

## Timing
- Reset values: state IDLE; busy, done, pass, ff_valid all 0; vec_cnt, err_cnt, ff_a, ff_b, ff_cin all 0; sig 16'hFFFF.
- Reset always wins. Asserting rst mid-run aborts the run and restores the reset values on the next edge.
- start is registered:
  - With start high at edge N, busy is high after edge N.
  - A vld in the same cycle as start from IDLE or DONE is ignored.
  - start while in RUN is ignored.
- Compare latency is 1 cycle. A vector sampled at edge N is reflected in vec_cnt, err_cnt, ff_* and sig after edge N.
- End of run:
  - After the edge that samples vector NVEC, done is high and busy is low in the same cycle.
  - pass is valid whenever done is high.
- vld may have gaps of any length. There is no backpressure: every vld cycle in RUN is consumed.

## Structure
- Shared package adder_pkg:
  - WIDTH default.
  - MISR_MASK = 16'h1021 and MISR_SEED = 16'hFFFF.
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module, misr16: a combinational next-signature function taking sig and a 16-bit data input. It is shared with future stimulus and signature blocks.
- The golden add is inline behavioural arithmetic, not an instance of the adder under test.

## Test plan
- Correct responses to all 512 vectors at WIDTH=4, vld held high:
  - Required: done high the cycle after the last vector, pass=1, err_cnt=0, vec_cnt=512, ff_valid=0.
- Fault at a=4'h3, b=4'h5, cin=1 (response s=4'h0, cout=0 instead of s=9, cout=0), all other vectors correct:
  - Required: err_cnt=1, ff_valid=1, ff_a=3, ff_b=5, ff_cin=1, pass=0.
  - Required: sig differs from the fault-free run.
- Two faults, at (1,1,0) then (15,15,1):
  - Required: err_cnt=2 and ff_* equal to (1,1,0).
- Two identical fault-free runs, started back-to-back from DONE:
  - Required: identical sig values.
  - Required: counters cleared at the second start.
- vld toggled with random gaps, plus start pulses injected mid-run:
  - Required: vec_cnt counts only vld cycles; the mid-run starts have no effect; done arrives after the 512th vector.
- rst asserted after 100 vectors:
  - Required: every output at its reset value on the next edge, and the block stays in IDLE until start.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder stimulus/response family:
// default operand width, signature constants and the checker state encoding.
package adder_pkg;

    localparam int ADDER_WIDTH = 4;

    localparam logic [15:0] MISR_MASK = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/misr16.sv
// Combinational next-state function of the 16-bit Galois MISR used for
// response signatures; shared by stimulus and signature blocks.
module misr16
    import adder_pkg::*;
(
    input  logic [15:0] i_sig,
    input  logic [15:0] i_data,
    output logic [15:0] o_sig_next
);

    logic [15:0] w_shifted;

    assign w_shifted  = {i_sig[14:0], 1'b0} ^ (i_sig[15] ? MISR_MASK : 16'h0000);
    assign o_sig_next = w_shifted ^ i_data;

endmodule

// File: rtl/adder_response_checker.sv
// Response analyzer for one exhaustive adder sweep: checks each vector against
// a golden sum, counts errors, captures the first failure and builds a signature.
module adder_response_checker
    import adder_pkg::*;
#(
    parameter  int WIDTH = ADDER_WIDTH,
    localparam int NVEC  = 1 << (2 * WIDTH + 1),
    localparam int CW    = 2 * WIDTH + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    vec_cnt,
    output logic [CW-1:0]    err_cnt,
    output logic             ff_valid,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic             ff_cin,
    output logic [15:0]      sig
);

    state_e           r_state;
    state_e           w_state_next;
    logic             w_clear;
    logic             w_accept;

    logic [CW-1:0]    r_vec_cnt;
    logic [CW-1:0]    r_err_cnt;
    logic             r_ff_valid;
    logic [WIDTH-1:0] r_ff_a;
    logic [WIDTH-1:0] r_ff_b;
    logic             r_ff_cin;
    logic [15:0]      r_sig;

    logic [WIDTH:0]   w_exp;
    logic [WIDTH:0]   w_resp;
    logic             w_mismatch;
    logic             w_last_vec;
    logic [15:0]      w_misr_data;
    logic [15:0]      w_sig_next;

    // Golden add is plain arithmetic at WIDTH+1 bits, independent of the DUT adder.
    assign w_exp      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign w_resp     = {cout, s};
    assign w_mismatch = (w_resp != w_exp);
    assign w_last_vec = (r_vec_cnt == CW'(NVEC - 1));

    assign w_misr_data = {{(15 - WIDTH){1'b0}}, w_resp};

    misr16 u_misr16 (
        .i_sig      (r_sig),
        .i_data     (w_misr_data),
        .o_sig_next (w_sig_next)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_clear      = 1'b1;
                end
            end
            ST_RUN: begin
                if (vld) begin
                    w_accept = 1'b1;
                    if (w_last_vec) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_cnt  <= '0;
            r_err_cnt  <= '0;
            r_ff_valid <= 1'b0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
            r_ff_cin   <= 1'b0;
            r_sig      <= MISR_SEED;
        end else if (w_clear) begin
            r_vec_cnt  <= '0;
            r_err_cnt  <= '0;
            r_ff_valid <= 1'b0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
            r_ff_cin   <= 1'b0;
            r_sig      <= MISR_SEED;
        end else if (w_accept) begin
            r_vec_cnt <= r_vec_cnt + CW'(1);
            r_sig     <= w_sig_next;
            if (w_mismatch) begin
                r_err_cnt <= r_err_cnt + CW'(1);
                // Only the first failure of a run is kept.
                if (!r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_a     <= a;
                    r_ff_b     <= b;
                    r_ff_cin   <= cin;
                end
            end
        end
    end

    assign busy     = (r_state == ST_RUN);
    assign done     = (r_state == ST_DONE);
    assign pass     = done && (r_err_cnt == '0);
    assign vec_cnt  = r_vec_cnt;
    assign err_cnt  = r_err_cnt;
    assign ff_valid = r_ff_valid;
    assign ff_a     = r_ff_a;
    assign ff_b     = r_ff_b;
    assign ff_cin   = r_ff_cin;
    assign sig      = r_sig;

endmodule

// File: tb/tb_adder_response_checker.sv
// Self-checking bench: exhaustive and shuffled sweeps with injected faults,
// random vld gaps, stray starts and a mid-run reset, against a behavioural model.
module tb_adder_response_checker;

    localparam int W    = 4;
    localparam int NVEC = 512;
    localparam int CW   = 10;

    logic          clk = 1'b0;
    logic          rst, start, vld, cin, cout;
    logic [W-1:0]  a, b, s;
    logic          busy, done, pass, ff_valid, ff_cin;
    logic [CW-1:0] vec_cnt, err_cnt;
    logic [W-1:0]  ff_a, ff_b;
    logic [15:0]   sig;

    adder_response_checker #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .vld(vld),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .busy(busy), .done(done), .pass(pass),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .ff_valid(ff_valid), .ff_a(ff_a), .ff_b(ff_b), .ff_cin(ff_cin),
        .sig(sig)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the checker's observable results.
    bit m_run, m_done, m_ffv;
    int m_vec, m_err, m_ffa, m_ffb, m_ffc, m_sig;
    int sig_a;

    function automatic int misr_step(int sg, int d);
        int n;
        n = (sg * 2) % 65536;
        if (sg >= 32768) n = n ^ 'h1021;
        return n ^ d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_ffv = 0;
        m_vec = 0; m_err = 0; m_ffa = 0; m_ffb = 0; m_ffc = 0;
        m_sig = 'hFFFF;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".busy"},     busy,     m_run);
        check({ctx, ".done"},     done,     m_done);
        check({ctx, ".pass"},     pass,     (m_done && m_err == 0));
        check({ctx, ".vec_cnt"},  vec_cnt,  m_vec);
        check({ctx, ".err_cnt"},  err_cnt,  m_err);
        check({ctx, ".ff_valid"}, ff_valid, m_ffv);
        check({ctx, ".ff_a"},     ff_a,     m_ffa);
        check({ctx, ".ff_b"},     ff_b,     m_ffb);
        check({ctx, ".ff_cin"},   ff_cin,   m_ffc);
        check({ctx, ".sig"},      sig,      m_sig);
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic cyc(input string ctx, input bit r, input bit st, input bit v,
                       input int ta, input int tb, input int tc, input int ts, input int tco);
        int exp, got;
        rst = r; start = st; vld = v;
        a = ta[W-1:0]; b = tb[W-1:0]; cin = tc[0]; s = ts[W-1:0]; cout = tco[0];
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else if (!m_run) begin
            if (st) begin
                model_reset();
                m_run = 1;
            end
        end else if (v) begin
            exp = ta + tb + tc;
            got = tco * 16 + ts;
            m_vec++;
            if (got != exp) begin
                m_err++;
                if (!m_ffv) begin
                    m_ffv = 1; m_ffa = ta; m_ffb = tb; m_ffc = tc;
                end
            end
            m_sig = misr_step(m_sig, got);
            if (m_vec == NVEC) begin
                m_run = 0; m_done = 1;
            end
        end
        check_all(ctx);
    endtask

    // Response of the "adder under test" for a given fault mode.
    function automatic int response(input int mode, input int ta, input int tb, input int tc);
        int r;
        r = ta + tb + tc;
        if (mode == 1 && ta == 3 && tb == 5 && tc == 1) r = 0;
        if (mode == 2 && ta == 1 && tb == 1 && tc == 0) r = 3;
        if (mode == 2 && ta == 15 && tb == 15 && tc == 1) r = 'h0F;
        if (mode == 3 && $urandom_range(0, 31) == 0) r = r ^ $urandom_range(1, 31);
        return r;
    endfunction

    task automatic sweep(input string ctx, input int mode, input bit shuffled,
                         input int gap_max, input bit mid_start, input bit start_vld);
        int order[NVEC];
        int tmp, j, idx, r, g;
        for (int i = 0; i < NVEC; i++) order[i] = i;
        if (shuffled) begin
            for (int i = NVEC - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = order[i]; order[i] = order[j]; order[j] = tmp;
            end
        end
        cyc({ctx, ".start"}, 0, 1, start_vld, $urandom_range(0, 15), $urandom_range(0, 15),
            0, $urandom_range(0, 15), 1);
        for (int i = 0; i < NVEC; i++) begin
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int k = 0; k < g; k++)
                cyc({ctx, ".gap"}, 0, mid_start && ($urandom_range(0, 3) == 0), 0,
                    $urandom_range(0, 15), $urandom_range(0, 15), 1, $urandom_range(0, 15), 0);
            idx = order[i];
            r = response(mode, idx / 32, (idx / 2) % 16, idx % 2);
            cyc({ctx, ".vec"}, 0, mid_start && ($urandom_range(0, 3) == 0), 1,
                idx / 32, (idx / 2) % 16, idx % 2, r % 16, r / 16);
        end
        check({ctx, ".done_end"}, done, 1);
        check({ctx, ".vec_end"}, vec_cnt, NVEC);
    endtask

    initial begin
        int r;
        model_reset();
        cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("reset", 1, 1, 1, 1, 1, 0, 0, 0);
        cyc("idle", 0, 0, 1, 1, 1, 0, 0, 0);

        // Fault-free exhaustive sweep, vld held high.
        sweep("runA", 0, 0, 0, 0, 0);
        check("runA.pass", pass, 1);
        check("runA.err", err_cnt, 0);
        check("runA.ffv", ff_valid, 0);
        sig_a = m_sig;

        // Identical run straight from DONE, with a stray vld on the start cycle.
        sweep("runB", 0, 0, 0, 0, 1);
        check("runB.sig_same", sig, sig_a);

        // Single fault at (3,5,1).
        sweep("runC", 1, 0, 0, 0, 0);
        check("runC.err", err_cnt, 1);
        check("runC.ffv", ff_valid, 1);
        check("runC.ffa", ff_a, 3);
        check("runC.ffb", ff_b, 5);
        check("runC.ffc", ff_cin, 1);
        check("runC.pass", pass, 0);
        check("runC.sig_differs", (sig != sig_a), 1);

        // Two faults, first one must stay captured.
        sweep("runD", 2, 0, 0, 0, 0);
        check("runD.err", err_cnt, 2);
        check("runD.ffa", ff_a, 1);
        check("runD.ffb", ff_b, 1);
        check("runD.ffc", ff_cin, 0);

        // Shuffled order, random gaps, stray starts, random faults.
        sweep("runE", 3, 1, 3, 1, 1);

        // Abort with reset after 100 vectors.
        cyc("runF.start", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            r = response(3, i / 32, (i / 2) % 16, i % 2);
            cyc("runF.vec", 0, 0, 1, i / 32, (i / 2) % 16, i % 2, r % 16, r / 16);
        end
        check("runF.vec100", vec_cnt, 100);
        cyc("runF.rst", 1, 1, 1, 2, 2, 0, 4, 0);
        check("runF.rst_busy", busy, 0);
        check("runF.rst_sig", sig, 16'hFFFF);
        for (int i = 0; i < 6; i++)
            cyc("runF.idle", 0, 0, 1, i, i, 0, 0, 0);
        check("runF.idle_vec", vec_cnt, 0);
        cyc("runF.restart", 0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc("runF.vec2", 0, 0, 1, i, i, 1, (2 * i + 1) % 16, 0);
        check("runF.vec4", vec_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
